// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: shared CLINT offsets, data width and bus FSM encodings
package clint_timer_pkg;
    localparam int DATA_BUS = 64;
    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
    typedef enum logic {CLINT_IDLE = 1'b0, CLINT_RESP = 1'b1} clint_state_e;
endpackage

// File: rtl/clint_byte_merge.sv
// clint_byte_merge: per-byte strobe merge of a new value over an old one
module clint_byte_merge
    import clint_timer_pkg::*;
(
    input  logic [DATA_BUS-1:0]   old_val,
    input  logic [DATA_BUS-1:0]   new_val,
    input  logic [DATA_BUS/8-1:0] strb,
    output logic [DATA_BUS-1:0]   merged
);
    for (genvar i = 0; i < DATA_BUS / 8; i++) begin : g_byte
        assign merged[8*i+:8] = strb[i] ? new_val[8*i+:8] : old_val[8*i+:8];
    end
endmodule

// File: rtl/clint_timer.sv
// clint_timer: core-local mtime/mtimecmp timer on the data bus; CLINT_MSIP_EN adds msip at offset 0
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int                  ADDR_W    = 16,
    parameter int                  TICK_DIV  = 1,
    parameter logic [DATA_BUS-1:0] MTIME_RST = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_BUS-1:0]   req_wdata,
    input  logic [DATA_BUS/8-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_BUS-1:0]   rsp_rdata,
    output logic                  rsp_err,
`ifdef CLINT_MSIP_EN
    output logic                  clint_msip,
`endif
    output logic                  clint_mtip,
    output logic [DATA_BUS-1:0]   mtime
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    clint_state_e        state;
    logic [PW-1:0]       presc;
    logic [DATA_BUS-1:0] mtimecmp, mtime_inc, mtime_wr, cmp_wr, rd_data;
    logic [ADDR_W-1:0]   base;
    logic                tick, acc, wr, hit_msip, hit_cmp, hit_time, msip_bit;
    assign base      = req_addr & ~ADDR_W'(7);
    assign hit_cmp   = base == ADDR_W'(CLINT_MTIMECMP_OFF);
    assign hit_time  = base == ADDR_W'(CLINT_MTIME_OFF);
    assign acc       = state == CLINT_IDLE && req_valid;
    assign wr        = acc && req_we;
    assign req_ready = state == CLINT_IDLE;
    assign tick      = presc == PW'(TICK_DIV - 1);
    assign mtime_inc = mtime + DATA_BUS'(tick);
    // Strobes gated by the decode so a tick still lands in unwritten bytes
    clint_byte_merge u_mtime_merge (
        .old_val(mtime_inc),
        .new_val(req_wdata),
        .strb   (req_wstrb & {(DATA_BUS/8){wr && hit_time}}),
        .merged (mtime_wr)
    );
    clint_byte_merge u_cmp_merge (
        .old_val(mtimecmp),
        .new_val(req_wdata),
        .strb   (req_wstrb & {(DATA_BUS/8){wr && hit_cmp}}),
        .merged (cmp_wr)
    );
`ifdef CLINT_MSIP_EN
    assign hit_msip   = base == ADDR_W'(CLINT_MSIP_OFF);
    assign clint_msip = msip_bit;
    always_ff @(posedge clk) begin
        if (rst)
            msip_bit <= 1'b0;
        else if (wr && hit_msip && req_wstrb[0])
            msip_bit <= req_wdata[0];
    end
`else
    assign hit_msip = 1'b0;
    assign msip_bit = 1'b0;
`endif
    always_comb
        rd_data = hit_time ? mtime : hit_cmp ? mtimecmp : hit_msip ? {{(DATA_BUS-1){1'b0}}, msip_bit} : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLINT_IDLE;
            presc      <= '0;
            mtime      <= MTIME_RST;
            mtimecmp   <= '1;
            clint_mtip <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + PW'(1);
            mtime      <= mtime_wr;
            mtimecmp   <= cmp_wr;
            clint_mtip <= mtime >= mtimecmp;
            if (acc) begin
                state     <= CLINT_RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= req_we ? '0 : rd_data;
                rsp_err   <= !(hit_msip || hit_cmp || hit_time);
            end else if (state == CLINT_RESP && rsp_ready) begin
                state     <= CLINT_IDLE;
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: table-driven register checks plus timer/backpressure/reset sequences
module tb_clint_timer;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_err, clint_mtip;
    logic [63:0] rsp_rdata, mtime;
`ifdef CLINT_MSIP_EN
    logic        clint_msip;
`endif
    int pass_cnt = 0, total = 0;
    logic        r_valid, r_err, r_mtip;
    logic [63:0] r_data;

    clint_timer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef CLINT_MSIP_EN
        .clint_msip(clint_msip),
`endif
        .clint_mtip(clint_mtip), .mtime(mtime)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Starts 1 time unit after an edge with the DUT idle; returns 1 unit after the handshake edge
    task automatic do_req(input logic we, input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        @(posedge clk); #1;
        req_valid = 0; req_we = 0; req_wstrb = '0;
        r_valid = rsp_valid; r_data = rsp_rdata; r_err = rsp_err; r_mtip = clint_mtip;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[10];

    initial begin
        vecs[0] = '{1, 16'h4000, 64'hAABBCCDD_11223344, 8'h0F, 64'h0, 0};
        vecs[1] = '{0, 16'h4000, 64'h0, 8'h00, 64'hFFFFFFFF_11223344, 0};
        vecs[2] = '{1, 16'h4000, 64'h55667788_99999999, 8'hF0, 64'h0, 0};
        vecs[3] = '{0, 16'h4000, 64'h0, 8'h00, 64'h55667788_11223344, 0};
        vecs[4] = '{1, 16'h4000, 64'h0, 8'h00, 64'h0, 0};
        vecs[5] = '{0, 16'h4004, 64'h0, 8'h00, 64'h55667788_11223344, 0};
        vecs[6] = '{0, 16'h1234, 64'h0, 8'h00, 64'h0, 1};
        vecs[7] = '{1, 16'h1238, 64'hFF, 8'hFF, 64'h0, 1};
`ifdef CLINT_MSIP_EN
        vecs[8] = '{0, 16'h0000, 64'h0, 8'h00, 64'h0, 0};
`else
        vecs[8] = '{0, 16'h0000, 64'h0, 8'h00, 64'h0, 1};
`endif
        vecs[9] = '{1, 16'h4000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'h0, 0};

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_mtime", mtime, 64'h0);
        chk("reset_mtip", {63'b0, clint_mtip}, 64'h0);
        chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'h0);
        chk("reset_req_ready", {63'b0, req_ready}, 64'h1);
        repeat (10) @(posedge clk);
        #1 chk("idle10_mtime_port", mtime, 64'd10);
        do_req(0, 16'hBFF8, 64'h0, 8'h00);
        chk("idle10_mtime_read", r_data, 64'd10);
        chk("idle10_mtip", {63'b0, r_mtip}, 64'h0);

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            chk($sformatf("vec%0d_valid", i), {63'b0, r_valid}, 64'h1);
            chk($sformatf("vec%0d_rdata", i), r_data, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {63'b0, r_err}, {63'b0, vecs[i].exp_err});
        end

        // mtip rise and fall around mtimecmp = 0x20
        do_req(1, 16'hBFF8, 64'h0, 8'hFF);
        do_req(1, 16'h4000, 64'h20, 8'hFF);
        do_req(1, 16'hBFF8, 64'h10, 8'hFF);
        chk("mtime_after_write", mtime, 64'h11);
        begin
            int n = 0;
            while (mtime != 64'h20 && n < 100) begin
                chk($sformatf("mtip_low_at_%0h", mtime), {63'b0, clint_mtip}, 64'h0);
                @(posedge clk); #1; n++;
            end
            chk("mtime_reached_20", mtime, 64'h20);
        end
        chk("mtip_low_at_20", {63'b0, clint_mtip}, 64'h0);
        @(posedge clk); #1;
        chk("mtip_high_at_21", {63'b0, clint_mtip}, 64'h1);
        do_req(1, 16'h4000, 64'h1000, 8'hFF);
        chk("mtip_still_high_at_write", {63'b0, r_mtip}, 64'h1);
        chk("mtip_fell_after_cmp", {63'b0, clint_mtip}, 64'h0);

        // mtime wrap
        do_req(1, 16'hBFF8, 64'hFFFFFFFF_FFFFFFFE, 8'hFF);
        chk("wrap_ff", mtime, 64'hFFFFFFFF_FFFFFFFF);
        chk("wrap_mtip_ff", {63'b0, clint_mtip}, 64'h1);
        @(posedge clk); #1;
        chk("wrap_zero", mtime, 64'h0);
        chk("wrap_mtip_0", {63'b0, clint_mtip}, 64'h1);
        @(posedge clk); #1;
        chk("wrap_one", mtime, 64'h1);
        chk("wrap_mtip_1", {63'b0, clint_mtip}, 64'h0);

        // partial mtime write during a tick: low byte written, rest incremented
        do_req(1, 16'hBFF8, 64'h0000_0000_0000_00AA, 8'h01);
        chk("mtime_partial", mtime, 64'hAB);

        // held response on an unmapped read
        req_valid = 1; req_we = 0; req_addr = 16'h1234;
        @(posedge clk); #1;
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold%0d_valid", i), {63'b0, rsp_valid}, 64'h1);
            chk($sformatf("hold%0d_rdata", i), rsp_rdata, 64'h0);
            chk($sformatf("hold%0d_err", i), {63'b0, rsp_err}, 64'h1);
            chk($sformatf("hold%0d_ready", i), {63'b0, req_ready}, 64'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("hold_released", {63'b0, rsp_valid}, 64'h0);

        // held response on an mtime read: data must not track the running counter
        chk("hold_mtime_pre", mtime, 64'hB0);
        req_valid = 1; req_addr = 16'hBFF8;
        @(posedge clk); #1;
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("holdt%0d_rdata", i), rsp_rdata, 64'hB0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;

        // reset while a response is pending
        req_valid = 1; req_addr = 16'h4000;
        @(posedge clk); #1;
        req_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'h0);
        chk("rst_req_ready", {63'b0, req_ready}, 64'h1);
        chk("rst_mtime", mtime, 64'h0);
        chk("rst_mtip", {63'b0, clint_mtip}, 64'h0);

`ifdef CLINT_MSIP_EN
        do_req(1, 16'h0000, 64'h1, 8'h01);
        chk("msip_set", {63'b0, clint_msip}, 64'h1);
        do_req(0, 16'h0000, 64'h0, 8'h00);
        chk("msip_read", r_data, 64'h1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
